// File: rtl/wb_queue.sv
//==============================================================================
// Module  : wb_queue
// Brief   : Writeback queue between MEM stage and the register-file write port.
//           In-order FIFO of completed results, one register write per cycle,
//           flush support and two forwarding lookups over uncommitted results.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          IN_MEMTOREG,
    input  logic [31:0]   IN_ALU_RESULT,
    input  logic [31:0]   IN_MEM_DATA,
    input  logic [4:0]    IN_REG,
    input  logic          WB_EN,
    input  logic          FLUSH,
    output logic          REG_WRITE,
    output logic [4:0]    WRITE_REGISTER,
    output logic [31:0]   WRITE_DATA,
    input  logic [4:0]    FWD_REG1,
    input  logic [4:0]    FWD_REG2,
    output logic          FWD_HIT1,
    output logic          FWD_HIT2,
    output logic [31:0]   FWD_DATA1,
    output logic [31:0]   FWD_DATA2,
    output logic [CW-1:0] COUNT
);

    localparam int AW = CW - 1;

    logic [4:0]    ent_reg_q  [DEPTH];
    logic [4:0]    ent_reg_d  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_register_q, write_register_d;
    logic [31:0]   write_data_q, write_data_d;

    logic          do_push;
    logic          do_pop;
    logic [31:0]   in_data;

    assign IN_READY       = (count_q != CW'(DEPTH));
    assign COUNT          = count_q;
    assign REG_WRITE      = reg_write_q;
    assign WRITE_REGISTER = write_register_q;
    assign WRITE_DATA     = write_data_q;

    // Transfers to r0 complete the handshake but never occupy an entry;
    // flush discards both the incoming transfer and any dequeue.
    assign in_data = IN_MEMTOREG ? IN_MEM_DATA : IN_ALU_RESULT;
    assign do_push = IN_VALID && IN_READY && (IN_REG != 5'd0) && !FLUSH;
    assign do_pop  = WB_EN && (count_q != '0) && !FLUSH;

    // Next-state computation for FIFO storage, pointers and output register.
    always_comb begin
        ent_reg_d        = ent_reg_q;
        ent_data_d       = ent_data_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        count_d          = count_q;
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                ent_reg_d[wptr_q]  = IN_REG;
                ent_data_d[wptr_q] = in_data;
                wptr_d             = wptr_q + 1'b1;
            end
            if (do_pop) begin
                reg_write_d      = 1'b1;
                write_register_d = ent_reg_q[rptr_q];
                write_data_d     = ent_data_q[rptr_q];
                rptr_d           = rptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            ent_reg_q        <= ent_reg_d;
            ent_data_q       <= ent_data_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    // Youngest-match search: the output register is the oldest candidate,
    // then FIFO entries from oldest to newest so later matches override.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] q);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        if (q != 5'd0) begin
            if (reg_write_q && (write_register_q == q)) begin
                res = {1'b1, write_data_q};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rptr_q + AW'(i);
                if ((CW'(i) < count_q) && (ent_reg_q[idx] == q)) begin
                    res = {1'b1, ent_data_q[idx]};
                end
            end
        end
        return res;
    endfunction

    // Forwarding results for both read-side query ports.
    always_comb begin
        {FWD_HIT1, FWD_DATA1} = fwd_lookup(FWD_REG1);
        {FWD_HIT2, FWD_DATA2} = fwd_lookup(FWD_REG2);
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
//==============================================================================
// Module  : tb_wb_queue
// Brief   : Self-checking bench for wb_queue with a write-port scoreboard.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_queue;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_MEMTOREG;
    logic [31:0] IN_ALU_RESULT;
    logic [31:0] IN_MEM_DATA;
    logic [4:0]  IN_REG;
    logic        WB_EN;
    logic        FLUSH;
    logic        REG_WRITE;
    logic [4:0]  WRITE_REGISTER;
    logic [31:0] WRITE_DATA;
    logic [4:0]  FWD_REG1, FWD_REG2;
    logic        FWD_HIT1, FWD_HIT2;
    logic [31:0] FWD_DATA1, FWD_DATA2;
    logic [2:0]  COUNT;

    int errors = 0;
    int checks = 0;
    logic [36:0] sb[$];

    wb_queue #(.DEPTH(4), .CW(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_MEMTOREG(IN_MEMTOREG), .IN_ALU_RESULT(IN_ALU_RESULT),
        .IN_MEM_DATA(IN_MEM_DATA), .IN_REG(IN_REG), .WB_EN(WB_EN), .FLUSH(FLUSH),
        .REG_WRITE(REG_WRITE), .WRITE_REGISTER(WRITE_REGISTER), .WRITE_DATA(WRITE_DATA),
        .FWD_REG1(FWD_REG1), .FWD_REG2(FWD_REG2), .FWD_HIT1(FWD_HIT1), .FWD_HIT2(FWD_HIT2),
        .FWD_DATA1(FWD_DATA1), .FWD_DATA2(FWD_DATA2), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && REG_WRITE === 1'b1) begin
            logic [36:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected no write",
                         WRITE_REGISTER, WRITE_DATA);
            end else begin
                e = sb.pop_front();
                if ({WRITE_REGISTER, WRITE_DATA} !== e) begin
                    errors++;
                    $display("FAIL write_order: got reg %0d data 0x%08h expected reg %0d data 0x%08h",
                             WRITE_REGISTER, WRITE_DATA, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one result; exp_data is the hand-computed stored value.
    task automatic send(input logic [4:0] r, input logic [31:0] alu, input logic [31:0] mem,
                        input logic m2r, input logic [31:0] exp_data);
        int n;
        IN_VALID = 1'b1; IN_REG = r; IN_ALU_RESULT = alu; IN_MEM_DATA = mem; IN_MEMTOREG = m2r;
        n = 0;
        while (IN_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got IN_READY=%b expected 1", IN_READY);
        end else begin
            if (r != 5'd0) sb.push_back({r, exp_data});
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; IN_MEMTOREG = 1'b0; IN_ALU_RESULT = '0;
        IN_MEM_DATA = '0; IN_REG = '0; WB_EN = 1'b0; FLUSH = 1'b0;
        FWD_REG1 = '0; FWD_REG2 = '0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
        check("reset_in_ready", 32'(IN_READY), 32'd1);
        check("reset_count", 32'(COUNT), 32'd0);
        check("reset_reg_write", 32'(REG_WRITE), 32'd0);
        check("reset_write_register", 32'(WRITE_REGISTER), 32'd0);
        check("reset_write_data", WRITE_DATA, 32'd0);

        // Single ALU result: write strobe in the cycle after the accept edge.
        WB_EN = 1'b1;
        send(5'd5, 32'h0000_00AA, 32'h0, 1'b0, 32'h0000_00AA);
        tick();
        check("single_strobe", 32'(REG_WRITE), 32'd1);
        check("single_reg", 32'(WRITE_REGISTER), 32'd5);
        check("single_data", WRITE_DATA, 32'hAA);
        tick();
        check("single_strobe_off", 32'(REG_WRITE), 32'd0);
        check("hold_reg", 32'(WRITE_REGISTER), 32'd5);

        // Fill with writeback stalled, then drain in order.
        WB_EN = 1'b0;
        send(5'd1, 32'h11, 32'h0, 1'b0, 32'h11);
        send(5'd2, 32'h22, 32'h0, 1'b0, 32'h22);
        send(5'd3, 32'h33, 32'h0, 1'b0, 32'h33);
        send(5'd4, 32'h44, 32'h0, 1'b0, 32'h44);
        check("full_in_ready", 32'(IN_READY), 32'd0);
        check("full_count", 32'(COUNT), 32'd4);
        IN_VALID = 1'b1; IN_REG = 5'd6; IN_ALU_RESULT = 32'h66;
        tick(); tick();
        check("stalled_count", 32'(COUNT), 32'd4);
        check("stalled_no_write", 32'(REG_WRITE), 32'd0);
        IN_VALID = 1'b0;
        WB_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_strobe", 32'(REG_WRITE), 32'd1);
        end
        check("drained_in_ready", 32'(IN_READY), 32'd1);
        check("drained_count", 32'(COUNT), 32'd0);
        tick();

        // Memory data select and r0 drop.
        send(5'd9, 32'h1234, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("mem_data", WRITE_DATA, 32'hDEAD_BEEF);
        tick();
        send(5'd0, 32'h5555, 32'h0, 1'b0, 32'h0);
        check("r0_count", 32'(COUNT), 32'd0);
        tick();
        check("r0_no_write", 32'(REG_WRITE), 32'd0);

        // Forwarding: newest FIFO entry wins, then output register.
        WB_EN = 1'b0;
        send(5'd7, 32'h1, 32'h0, 1'b0, 32'h1);
        send(5'd7, 32'h2, 32'h0, 1'b0, 32'h2);
        FWD_REG1 = 5'd7; FWD_REG2 = 5'd0;
        #1;
        check("fwd1_hit", 32'(FWD_HIT1), 32'd1);
        check("fwd1_data", FWD_DATA1, 32'h2);
        check("fwd2_r0_hit", 32'(FWD_HIT2), 32'd0);
        check("fwd2_r0_data", FWD_DATA2, 32'h0);
        FWD_REG2 = 5'd8;
        #1;
        check("fwd2_miss", 32'(FWD_HIT2), 32'd0);
        WB_EN = 1'b1;
        tick();
        check("fwd_partial_data", FWD_DATA1, 32'h2);
        tick();
        check("fwd_outreg_hit", 32'(FWD_HIT1), 32'd1);
        check("fwd_outreg_data", FWD_DATA1, 32'h2);
        tick();
        check("fwd_committed_hit", 32'(FWD_HIT1), 32'd0);
        check("fwd_committed_data", FWD_DATA1, 32'h0);

        // Flush at COUNT=3 with a write in flight and a concurrent input.
        WB_EN = 1'b0;
        send(5'd10, 32'hA0, 32'h0, 1'b0, 32'hA0);
        send(5'd11, 32'hB0, 32'h0, 1'b0, 32'hB0);
        send(5'd12, 32'hC0, 32'h0, 1'b0, 32'hC0);
        send(5'd13, 32'hD0, 32'h0, 1'b0, 32'hD0);
        WB_EN = 1'b1;
        tick();
        WB_EN = 1'b0;
        check("preflush_count", 32'(COUNT), 32'd3);
        check("preflush_strobe", 32'(REG_WRITE), 32'd1);
        FLUSH = 1'b1; IN_VALID = 1'b1; IN_REG = 5'd14; IN_ALU_RESULT = 32'hEE;
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        sb.delete();
        check("flush_count", 32'(COUNT), 32'd0);
        check("flush_strobe", 32'(REG_WRITE), 32'd0);
        check("flush_hold_reg", 32'(WRITE_REGISTER), 32'd10);
        WB_EN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("final_count", 32'(COUNT), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback-side producer for the 32x32 register file write port; drives REG_WRITE, WRITE_REGISTER and WRITE_DATA.
- Accepts completed results from the MEM stage over a valid/ready handshake and selects ALU result or memory data.
- Buffers results in a small in-order FIFO and retires at most one register write per cycle.
- Provides two forwarding lookups so the read side can see results that are not yet committed.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CW, 3, COUNT width; equals log2(DEPTH)+1.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST_N  input  1  synchronous, active-low reset.
IN_VALID  input  1  MEM stage presents a result.
IN_READY  output  1  queue can accept; a transfer occurs when IN_VALID and IN_READY are both high at the edge.
IN_MEMTOREG  input  1  1 selects IN_MEM_DATA, 0 selects IN_ALU_RESULT.
IN_ALU_RESULT  input  32  ALU result.
IN_MEM_DATA  input  32  data memory read value.
IN_REG  input  5  destination register.
WB_EN  input  1  1 allows a dequeue this cycle; 0 stalls the register-file side.
FLUSH  input  1  discard all queued, uncommitted entries.
REG_WRITE  output  1  write strobe to the register file.
WRITE_REGISTER  output  5  write address.
WRITE_DATA  output  32  write data.
FWD_REG1, FWD_REG2  input  5 each  forwarding query addresses.
FWD_HIT1, FWD_HIT2  output  1 each  a pending value exists for the query.
FWD_DATA1, FWD_DATA2  output  32 each  forwarded value; 0 on miss.
COUNT  output  CW  current FIFO occupancy.

Behaviour:
- Reset (RST_N=0 at edge):
  - Read/write pointers and COUNT go to 0.
  - REG_WRITE=0, WRITE_REGISTER=0, WRITE_DATA=0.
  - Reset mid-operation drops all entries; a REG_WRITE already high goes low on that edge.
- IN_READY = (COUNT != DEPTH); combinational from registered state only, with no dependence on IN_VALID or WB_EN.
- Enqueue on a transfer:
  - The stored entry is {IN_REG, IN_MEMTOREG ? IN_MEM_DATA : IN_ALU_RESULT}.
  - IN_REG==0 completes the handshake but stores nothing; COUNT does not change.
- Dequeue when WB_EN=1 and COUNT>0:
  - The oldest entry is removed.
  - On the next edge REG_WRITE=1 and WRITE_REGISTER/WRITE_DATA take that entry.
  - Latency: a result accepted at edge N into an empty queue with WB_EN=1 produces REG_WRITE=1 during cycle N+1..N+2, i.e. it is dequeued at edge N+1.
  - An entry is never dequeued in the same edge it is enqueued.
- REG_WRITE is high for exactly one cycle per dequeued entry. Back-to-back entries give consecutive high cycles. When no dequeue occurs, REG_WRITE=0 and WRITE_REGISTER/WRITE_DATA hold their last values.
- Simultaneous enqueue and dequeue: COUNT unchanged. This is legal at any COUNT from 1 to DEPTH-1. At COUNT=DEPTH no enqueue is possible because IN_READY=0.
- Pointers wrap modulo DEPTH; COUNT distinguishes full from empty.
- FLUSH=1 at edge:
  - Pointers and COUNT go to 0.
  - A concurrent input transfer is discarded.
  - No dequeue occurs, so REG_WRITE=0 next cycle.
  - The output currently driven with REG_WRITE=1 in the flush cycle is not cancelled; that write commits.
  - FLUSH has priority over enqueue and dequeue; RST_N has priority over FLUSH.
- Forwarding (combinational, per query port):
  - Search all valid FIFO entries plus the output register when REG_WRITE=1.
  - The youngest match wins: the newest FIFO entry first, the output register last.
  - A query of register 0 always misses, with FWD_DATA=0.
  - A miss gives FWD_HIT=0 and FWD_DATA=0.
- No X-filtering of data; every stored field is defined after reset.

Test Plan:
- Reset then idle → IN_READY=1, COUNT=0, REG_WRITE=0, WRITE_REGISTER=0, WRITE_DATA=0.
- Single ALU result, IN_REG=5, IN_ALU_RESULT=0x0000_00AA, IN_MEMTOREG=0, WB_EN=1 → REG_WRITE=1 for one cycle, the cycle after the accept edge, with WRITE_REGISTER=5, WRITE_DATA=0xAA.
- WB_EN=0, enqueue 4 entries (regs 1..4, data 0x11..0x44):
  - IN_READY=0 and COUNT=4.
  - A 5th IN_VALID is stalled.
  - Raising WB_EN gives 4 consecutive writes 1..4 in order, after which IN_READY=1.
- Memory select and r0 drop:
  - IN_MEMTOREG=1, IN_MEM_DATA=0xDEAD_BEEF, IN_REG=9 → WRITE_DATA=0xDEADBEEF.
  - IN_REG=0 accepted → COUNT unchanged, no REG_WRITE.
- Forwarding with WB_EN=0, reg 7 enqueued as 0x1 then 0x2:
  - FWD_REG1=7 → HIT=1, DATA=0x2.
  - FWD_REG2=0 → HIT=0, DATA=0.
- FLUSH at COUNT=3 with concurrent IN_VALID and REG_WRITE=1 in that cycle:
  - The in-flight write commits.
  - Next cycle COUNT=0 and REG_WRITE=0; the concurrent input is never written.
